char_motion: RTL and testbench

Generates the player character's world position (char_X, char_Y) from the button inputs. It handles walking, jumping and falling back to ground. Its outputs feed the scroll block, and it reads back bg_pos so the character can never walk left of the visible window. All motion updates happen on an internal tick pulse derived from sys_clk; no derived clocks are used.

---
 rtl/char_motion.sv | 141 ++++++++++++++
 tb/tb_char_motion.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/char_motion.sv
// Player character motion: walking with scroll-window clamping, jump/fall FSM,
// all updates gated by an internally divided motion tick.
module char_motion #(
    parameter int TICK_DIV   = 1000000,
    parameter int STEP_X     = 2,
    parameter int STEP_Y     = 4,
    parameter int JUMP_TICKS = 8,
    parameter int GROUND_Y   = 400,
    parameter int X_START    = 100,
    parameter int X_MAX      = 1000
) (
    input  logic       sys_clk,
    input  logic       sys_rst,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_jump,
    input  logic [9:0] bg_pos,
    output logic [9:0] char_X,
    output logic [9:0] char_Y,
    output logic       on_ground,
    output logic       facing_right,
    output logic       tick
);

    localparam int CNT_W = $clog2(TICK_DIV);
    localparam int RC_W  = $clog2(JUMP_TICKS + 1);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [RC_W-1:0]  RC_LAST  = RC_W'(JUMP_TICKS);
    localparam logic [10:0]      SX       = 11'(STEP_X);
    localparam logic [10:0]      SY       = 11'(STEP_Y);
    localparam logic [10:0]      GY       = 11'(GROUND_Y);
    localparam logic [10:0]      XMAX     = 11'(X_MAX);

    typedef enum logic [1:0] {GROUND, RISE, FALL} state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             jump_q;
    logic             jump_pend_q, jump_pend_d;
    logic [9:0]       x_q, x_d;
    logic             facing_q, facing_d;
    logic [9:0]       y_q;
    state_t           state_q;
    logic [RC_W-1:0]  rise_cnt_q;
    logic             on_ground_q;

    logic        tick_w;
    logic        jump_edge;
    logic        jump_now;
    logic [10:0] x_w, bg_w, y_w;

    assign tick_w    = (cnt_q == CNT_LAST);
    assign jump_edge = btn_jump & ~jump_q;
    // An edge arriving on the tick cycle itself still triggers that tick's jump.
    assign jump_now  = jump_pend_q | jump_edge;
    assign x_w       = {1'b0, x_q};
    assign bg_w      = {1'b0, bg_pos};
    assign y_w       = {1'b0, y_q};

    always_comb begin
        cnt_d       = tick_w ? '0 : cnt_q + CNT_W'(1);
        jump_pend_d = tick_w ? 1'b0 : (jump_pend_q | jump_edge);

        x_d      = x_q;
        facing_d = facing_q;
        if (btn_left && !btn_right) begin
            facing_d = 1'b0;
            // Compare before subtracting so small X never wraps.
            if (x_w < bg_w + SX) x_d = bg_pos;
            else                 x_d = 10'(x_w - SX);
        end else if (btn_right && !btn_left) begin
            facing_d = 1'b1;
            if (x_w + SX > XMAX) x_d = XMAX[9:0];
            else                 x_d = 10'(x_w + SX);
        end
        if (x_w < bg_w) x_d = bg_pos;
    end

    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            cnt_q       <= '0;
            jump_q      <= 1'b0;
            jump_pend_q <= 1'b0;
            x_q         <= 10'(X_START);
            facing_q    <= 1'b1;
            y_q         <= GY[9:0];
            state_q     <= GROUND;
            rise_cnt_q  <= '0;
            on_ground_q <= 1'b1;
        end else begin
            cnt_q       <= cnt_d;
            jump_q      <= btn_jump;
            jump_pend_q <= jump_pend_d;
            if (tick_w) begin
                x_q      <= x_d;
                facing_q <= facing_d;
                case (state_q)
                    GROUND: begin
                        y_q <= GY[9:0];
                        if (jump_now) begin
                            state_q     <= RISE;
                            y_q         <= 10'(GY - SY);
                            rise_cnt_q  <= RC_W'(1);
                            on_ground_q <= 1'b0;
                        end
                    end
                    RISE: begin
                        // Apex: hold Y for this tick and start falling.
                        if (rise_cnt_q == RC_LAST || y_w < SY) begin
                            state_q <= FALL;
                        end else begin
                            y_q        <= 10'(y_w - SY);
                            rise_cnt_q <= rise_cnt_q + RC_W'(1);
                        end
                    end
                    FALL: begin
                        if (y_w + SY >= GY) begin
                            y_q         <= GY[9:0];
                            state_q     <= GROUND;
                            on_ground_q <= 1'b1;
                        end else begin
                            y_q <= 10'(y_w + SY);
                        end
                    end
                    default: begin
                        state_q     <= GROUND;
                        y_q         <= GY[9:0];
                        on_ground_q <= 1'b1;
                    end
                endcase
            end
        end
    end

    assign char_X       = x_q;
    assign char_Y       = y_q;
    assign on_ground    = on_ground_q;
    assign facing_right = facing_q;
    assign tick         = tick_w;

endmodule

// File: tb/tb_char_motion.sv
// Directed bench for char_motion with a 4-cycle motion tick.
module tb_char_motion;

    logic       sys_clk = 1'b0;
    logic       sys_rst = 1'b0;
    logic       btn_left = 1'b0;
    logic       btn_right = 1'b0;
    logic       btn_jump = 1'b0;
    logic [9:0] bg_pos = 10'd0;
    logic [9:0] char_X;
    logic [9:0] char_Y;
    logic       on_ground;
    logic       facing_right;
    logic       tick;

    int vectors = 0;
    int miscompares = 0;

    char_motion #(.TICK_DIV(4)) dut (
        .sys_clk     (sys_clk),
        .sys_rst     (sys_rst),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_jump    (btn_jump),
        .bg_pos      (bg_pos),
        .char_X      (char_X),
        .char_Y      (char_Y),
        .on_ground   (on_ground),
        .facing_right(facing_right),
        .tick        (tick)
    );

    always #5 sys_clk = ~sys_clk;

    // Reset asserted and released between clock edges.
    task automatic reset_dut;
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
    endtask

    // Advance until the next tick has been applied; bounded wait.
    task automatic next_tick;
        int n = 0;
        while (tick !== 1'b1 && n < 12) begin
            @(posedge sys_clk); #1;
            n++;
        end
        vectors++;
        if (tick !== 1'b1) begin
            miscompares++;
            $display("FAIL tick_timeout: tick=%b after %0d cycles, required 1", tick, n);
        end
        @(posedge sys_clk); #1;
    endtask

    task automatic test_reset;
        @(posedge sys_clk); #2;
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (char_X !== 10'd100 || char_Y !== 10'd400 || on_ground !== 1'b1 ||
            facing_right !== 1'b1 || tick !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_async: X=%0d Y=%0d og=%b fr=%b tick=%b, required 100 400 1 1 0",
                     char_X, char_Y, on_ground, facing_right, tick);
        end
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        for (int k = 1; k <= 8; k++) begin
            @(posedge sys_clk); #1;
            vectors++;
            if (tick !== ((k % 4) == 3)) begin
                miscompares++;
                $display("FAIL tick_phase: edge %0d tick=%b, required %b", k, tick, (k % 4) == 3);
            end
        end
        vectors++;
        if (char_X !== 10'd100 || char_Y !== 10'd400 || on_ground !== 1'b1 || facing_right !== 1'b1) begin
            miscompares++;
            $display("FAIL reset_idle: X=%0d Y=%0d og=%b fr=%b, required 100 400 1 1",
                     char_X, char_Y, on_ground, facing_right);
        end
    endtask

    task automatic test_walk;
        reset_dut();
        bg_pos = 10'd0;
        btn_right = 1'b1;
        repeat (10) next_tick();
        vectors++;
        if (char_X !== 10'd120 || facing_right !== 1'b1) begin
            miscompares++;
            $display("FAIL walk_right: X=%0d fr=%b, required 120 1", char_X, facing_right);
        end
        btn_right = 1'b0;
        btn_left = 1'b1;
        repeat (3) next_tick();
        vectors++;
        if (char_X !== 10'd114 || facing_right !== 1'b0) begin
            miscompares++;
            $display("FAIL walk_left: X=%0d fr=%b, required 114 0", char_X, facing_right);
        end
        btn_left = 1'b0;
    endtask

    task automatic test_jump;
        logic [9:0] exp_y;
        logic       exp_og;
        reset_dut();
        btn_jump = 1'b1;
        @(posedge sys_clk); #1;
        btn_jump = 1'b0;
        for (int i = 1; i <= 18; i++) begin
            if (i == 4) begin
                btn_jump = 1'b1;
                @(posedge sys_clk); #1;
                btn_jump = 1'b0;
            end
            next_tick();
            if (i <= 8)       exp_y = 10'(400 - 4 * i);
            else if (i == 9)  exp_y = 10'd368;
            else if (i <= 17) exp_y = 10'(368 + 4 * (i - 9));
            else              exp_y = 10'd400;
            exp_og = (i >= 17);
            vectors++;
            if (char_Y !== exp_y || on_ground !== exp_og) begin
                miscompares++;
                $display("FAIL jump_traj: tick %0d Y=%0d og=%b, required %0d %b",
                         i, char_Y, on_ground, exp_y, exp_og);
            end
        end
    endtask

    task automatic test_left_clamp;
        reset_dut();
        bg_pos = 10'd99;
        btn_left = 1'b1;
        next_tick();
        vectors++;
        if (char_X !== 10'd99 || facing_right !== 1'b0) begin
            miscompares++;
            $display("FAIL lclamp_first: X=%0d fr=%b, required 99 0", char_X, facing_right);
        end
        next_tick();
        vectors++;
        if (char_X !== 10'd99) begin
            miscompares++;
            $display("FAIL lclamp_hold: X=%0d, required 99", char_X);
        end
        bg_pos = 10'd105;
        next_tick();
        vectors++;
        if (char_X !== 10'd105) begin
            miscompares++;
            $display("FAIL lclamp_snap_left: X=%0d, required 105", char_X);
        end
        btn_left = 1'b0;
        btn_right = 1'b1;
        bg_pos = 10'd110;
        next_tick();
        vectors++;
        if (char_X !== 10'd110 || facing_right !== 1'b1) begin
            miscompares++;
            $display("FAIL lclamp_snap_right: X=%0d fr=%b, required 110 1", char_X, facing_right);
        end
        btn_right = 1'b0;
        bg_pos = 10'd0;
    endtask

    task automatic test_right_clamp;
        reset_dut();
        bg_pos = 10'd999;
        next_tick();
        vectors++;
        if (char_X !== 10'd999) begin
            miscompares++;
            $display("FAIL rclamp_setup: X=%0d, required 999", char_X);
        end
        bg_pos = 10'd0;
        btn_right = 1'b1;
        next_tick();
        vectors++;
        if (char_X !== 10'd1000) begin
            miscompares++;
            $display("FAIL rclamp_first: X=%0d, required 1000", char_X);
        end
        next_tick();
        vectors++;
        if (char_X !== 10'd1000) begin
            miscompares++;
            $display("FAIL rclamp_hold: X=%0d, required 1000", char_X);
        end
        btn_right = 1'b0;
        btn_left = 1'b1;
        next_tick();
        vectors++;
        if (char_X !== 10'd998 || facing_right !== 1'b0) begin
            miscompares++;
            $display("FAIL rclamp_back: X=%0d fr=%b, required 998 0", char_X, facing_right);
        end
        btn_right = 1'b1;
        repeat (2) next_tick();
        vectors++;
        if (char_X !== 10'd998 || facing_right !== 1'b0) begin
            miscompares++;
            $display("FAIL both_buttons: X=%0d fr=%b, required 998 0", char_X, facing_right);
        end
        btn_left = 1'b0;
        btn_right = 1'b0;
    endtask

    task automatic test_reset_midjump;
        reset_dut();
        btn_right = 1'b1;
        btn_jump = 1'b1;
        @(posedge sys_clk); #1;
        btn_jump = 1'b0;
        repeat (5) next_tick();
        vectors++;
        if (char_Y !== 10'd380 || char_X !== 10'd110 || on_ground !== 1'b0) begin
            miscompares++;
            $display("FAIL midjump_pre: X=%0d Y=%0d og=%b, required 110 380 0", char_X, char_Y, on_ground);
        end
        #2;
        sys_rst = 1'b1;
        #1;
        vectors++;
        if (char_Y !== 10'd400 || char_X !== 10'd100 || on_ground !== 1'b1 || facing_right !== 1'b1) begin
            miscompares++;
            $display("FAIL midjump_reset: X=%0d Y=%0d og=%b fr=%b, required 100 400 1 1",
                     char_X, char_Y, on_ground, facing_right);
        end
        @(posedge sys_clk); #2;
        sys_rst = 1'b0;
        repeat (3) @(posedge sys_clk);
        #1;
        vectors++;
        if (char_X !== 10'd100 || tick !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_wait: X=%0d tick=%b, required 100 1", char_X, tick);
        end
        @(posedge sys_clk); #1;
        vectors++;
        if (char_X !== 10'd102 || char_Y !== 10'd400 || on_ground !== 1'b1) begin
            miscompares++;
            $display("FAIL resume_move: X=%0d Y=%0d og=%b, required 102 400 1", char_X, char_Y, on_ground);
        end
        btn_right = 1'b0;
    endtask

    initial begin
        test_reset();
        test_walk();
        test_jump();
        test_left_clamp();
        test_right_clamp();
        test_reset_midjump();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
